// File: rtl/dac_ad57x4_pkg.sv
// Shared frame format, register codes and sequencer states for the AD57x4 quad-DAC driver.
package dac_ad57x4_pkg;

  localparam int FRAME_W = 24;

  localparam logic [2:0] REG_DAC   = 3'b000;
  localparam logic [2:0] REG_RANGE = 3'b001;
  localparam logic [2:0] REG_POWER = 3'b010;

  typedef enum logic [2:0] {
    INIT_PWR, INIT_RNG, IDLE, SHIFT, GAP, LDAC, DONE
  } state_e;

  // {R/W=0, 0, REG, ADDR, DATA}, sent MSB first
  function automatic logic [FRAME_W-1:0] build_frame(input logic [2:0] rg,
                                                     input logic [2:0] addr,
                                                     input logic [15:0] data);
    return {2'b00, rg, addr, data};
  endfunction

endpackage

// File: rtl/dac_spi_frame_tx.sv
// 24-bit SPI frame shifter: SYNC low for the whole frame, SCLK idles high, data changes on SCLK rise.
module dac_spi_frame_tx
  import dac_ad57x4_pkg::*;
#(
  parameter int SCLK_DIV = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  output logic               last,
  output logic               sync_n,
  output logic               sclk,
  output logic               sdin
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic               active;
  logic [FRAME_W-1:0] shreg;
  logic [4:0]         bit_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic               div_end;

  assign div_end = (div_cnt == DIV_W'(SCLK_DIV - 1));
  // final cycle of the low half of bit 0; SYNC rises on the next edge
  assign last    = active && !sclk && div_end && (bit_cnt == 5'(FRAME_W - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active  <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      sync_n  <= 1'b1;
      sclk    <= 1'b1;
      sdin    <= 1'b0;
    end else if (start && !active) begin
      active  <= 1'b1;
      sync_n  <= 1'b0;
      sclk    <= 1'b1;
      sdin    <= frame[FRAME_W-1];
      shreg   <= {frame[FRAME_W-2:0], 1'b0};
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (active) begin
      if (!div_end) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        if (sclk) begin
          sclk <= 1'b0;
        end else if (last) begin
          active <= 1'b0;
          sync_n <= 1'b1;
          sclk   <= 1'b1;
          sdin   <= 1'b0;
        end else begin
          sclk    <= 1'b1;
          sdin    <= shreg[FRAME_W-1];
          shreg   <= {shreg[FRAME_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
    end
  end

endmodule

// File: rtl/dac_ad57x4_seq.sv
// Quad-DAC sequencer: power-up/range init after reset, then snapshot-and-write of enabled channels per trigger.
module dac_ad57x4_seq
  import dac_ad57x4_pkg::*;
#(
  parameter int         NUM_CH     = 4,
  parameter int         DATA_W     = 16,
  parameter int         SCLK_DIV   = 2,
  parameter logic [2:0] RANGE_CODE = 3'b000,
  parameter int         SYNC_GAP   = 2,
  parameter int         LDAC_MODE  = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     trig,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     init_done,
  output logic                     busy,
  output logic                     update_done,
  output logic                     dac_sync_n,
  output logic                     dac_sclk,
  output logic                     dac_sdin,
  output logic                     dac_ldac_n,
  output logic                     dac_clr_n
);

  localparam logic        LDAC_IDLE = (LDAC_MODE != 0);
  localparam logic [15:0] PWR_D     = 16'h0010 | 16'((1 << NUM_CH) - 1);
  localparam logic [15:0] RNG_D     = {13'b0, RANGE_CODE};

  state_e                   state, state_nx;
  logic [NUM_CH-1:0]        rem, src_en;
  logic [NUM_CH*DATA_W-1:0] snap_data, src_data;
  logic [1:0]               first;
  logic [DATA_W-1:0]        cur;
  logic [15:0]              cur16, cnt;
  logic [2:0]               rng_cnt;
  logic                     pending, accept, gap_end, ldac_end, start, tx_last, ldac_n_q;
  logic [FRAME_W-1:0]       frame;

  assign accept = (state == IDLE) && init_done && (trig || pending);

  // the first frame of an update is launched from the live inputs in the capture cycle
  assign src_en   = accept ? ch_en : rem;
  assign src_data = accept ? ch_data : snap_data;
  assign cur      = src_data[first*DATA_W +: DATA_W];
  assign cur16    = 16'(cur) << (16 - DATA_W);

  always_comb begin
    first = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (src_en[i]) first = 2'(i);
  end

  assign gap_end  = (state == GAP)  && (cnt == 16'(SYNC_GAP - 1));
  assign ldac_end = (state == LDAC) && (cnt == 16'(2*SCLK_DIV - 1));

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    frame    = build_frame(REG_DAC, {1'b0, first}, cur16);
    case (state)
      IDLE: begin
        if (!init_done) begin
          start    = 1'b1;
          frame    = build_frame(REG_POWER, 3'd0, PWR_D);
          state_nx = INIT_PWR;
        end else if (accept) begin
          if (ch_en == '0) state_nx = DONE;
          else begin
            start    = 1'b1;
            state_nx = SHIFT;
          end
        end
      end
      INIT_PWR, INIT_RNG, SHIFT: if (tx_last) state_nx = GAP;
      GAP: begin
        if (gap_end) begin
          if (!init_done) begin
            if (rng_cnt == 3'(NUM_CH)) state_nx = IDLE;
            else begin
              start    = 1'b1;
              frame    = build_frame(REG_RANGE, rng_cnt, RNG_D);
              state_nx = INIT_RNG;
            end
          end else if (rem != '0) begin
            start    = 1'b1;
            state_nx = SHIFT;
          end else begin
            state_nx = LDAC_IDLE ? LDAC : DONE;
          end
        end
      end
      LDAC:    if (ldac_end) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rng_cnt   <= '0;
      rem       <= '0;
      snap_data <= '0;
      pending   <= 1'b0;
      init_done <= 1'b0;
      ldac_n_q  <= LDAC_IDLE;
    end else begin
      state    <= state_nx;
      cnt      <= (state_nx != state) ? '0 : cnt + 16'd1;
      // triggers that cannot start now collapse into one deferred update
      pending  <= !accept && (pending || trig);
      ldac_n_q <= LDAC_IDLE && (state_nx != LDAC);
      if (accept) snap_data <= ch_data;
      if (start && state_nx == SHIFT)    rem     <= src_en & ~(NUM_CH'(1) << first);
      if (start && state_nx == INIT_RNG) rng_cnt <= rng_cnt + 3'd1;
      if (gap_end && !init_done && rng_cnt == 3'(NUM_CH)) init_done <= 1'b1;
    end
  end

  assign busy        = (state != IDLE);
  assign update_done = (state == DONE);
  assign dac_ldac_n  = ldac_n_q;
  assign dac_clr_n   = 1'b1;

  dac_spi_frame_tx #(.SCLK_DIV(SCLK_DIV)) u_tx (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .frame  (frame),
    .last   (tx_last),
    .sync_n (dac_sync_n),
    .sclk   (dac_sclk),
    .sdin   (dac_sdin)
  );

endmodule

// File: tb/tb_dac_ad57x4_seq.sv
// Bench: two sequencer configurations observed through an SPI-slave monitor and checked against a frame-list model.
module tb_dac_ad57x4_seq;

  localparam int A_N = 4, A_W = 16, A_D = 2, A_G = 2;
  localparam int B_N = 2, B_W = 12, B_D = 1, B_G = 3;
  localparam logic [2:0] B_RC = 3'b011;

  typedef logic [23:0] fq_t[$];

  logic clk, reset_n;
  logic a_trig, b_trig;
  logic [A_N-1:0] a_en;
  logic [B_N-1:0] b_en;
  logic [A_N*A_W-1:0] a_data;
  logic [B_N*B_W-1:0] b_data;
  logic a_init_done, a_busy, a_update_done, a_sync_n, a_sclk, a_sdin, a_ldac_n, a_clr_n;
  logic b_init_done, b_busy, b_update_done, b_sync_n, b_sclk, b_sdin, b_ldac_n, b_clr_n;

  int cyc = 0;
  int n_checks = 0, n_err = 0;

  dac_ad57x4_seq #(.NUM_CH(A_N), .DATA_W(A_W), .SCLK_DIV(A_D), .RANGE_CODE(3'b000),
                   .SYNC_GAP(A_G), .LDAC_MODE(0)) u_a (
    .clk(clk), .reset_n(reset_n), .trig(a_trig), .ch_en(a_en), .ch_data(a_data),
    .init_done(a_init_done), .busy(a_busy), .update_done(a_update_done),
    .dac_sync_n(a_sync_n), .dac_sclk(a_sclk), .dac_sdin(a_sdin),
    .dac_ldac_n(a_ldac_n), .dac_clr_n(a_clr_n));

  dac_ad57x4_seq #(.NUM_CH(B_N), .DATA_W(B_W), .SCLK_DIV(B_D), .RANGE_CODE(B_RC),
                   .SYNC_GAP(B_G), .LDAC_MODE(1)) u_b (
    .clk(clk), .reset_n(reset_n), .trig(b_trig), .ch_en(b_en), .ch_data(b_data),
    .init_done(b_init_done), .busy(b_busy), .update_done(b_update_done),
    .dac_sync_n(b_sync_n), .dac_sclk(b_sclk), .dac_sdin(b_sdin),
    .dac_ldac_n(b_ldac_n), .dac_clr_n(b_clr_n));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin @(posedge clk); cyc++; end

  // SPI slave view: shift on SCLK fall while SYNC low, close the frame on SYNC rise
  fq_t a_frames, b_frames;
  int a_falls[$], b_falls[$];
  logic [23:0] a_sh = '0, b_sh = '0;
  int a_bits = 0, b_bits = 0, a_partial = 0, b_rise_at = 0;
  int b_ldac_fall = 0, b_ldac_rise = 0, b_ldac_cnt = 0;
  int a_init_at = 0, b_init_at = 0, b_done_at = 0;

  initial forever begin @(negedge a_sclk); if (a_sync_n === 1'b0) begin a_sh = {a_sh[22:0], a_sdin}; a_bits++; end end
  initial forever begin @(negedge b_sclk); if (b_sync_n === 1'b0) begin b_sh = {b_sh[22:0], b_sdin}; b_bits++; end end
  initial forever begin
    @(posedge a_sync_n);
    if (a_bits == 24) a_frames.push_back(a_sh); else if (a_bits != 0) a_partial++;
    a_bits = 0;
  end
  initial forever begin
    @(posedge b_sync_n);
    if (b_bits == 24) b_frames.push_back(b_sh);
    b_bits = 0;
    b_rise_at = cyc;
  end
  initial forever begin @(negedge a_sync_n); a_falls.push_back(cyc); end
  initial forever begin @(negedge b_sync_n); b_falls.push_back(cyc); end
  initial forever begin @(negedge b_ldac_n); b_ldac_fall = cyc; b_ldac_cnt++; end
  initial forever begin @(posedge b_ldac_n); b_ldac_rise = cyc; end
  initial forever begin @(posedge a_init_done); a_init_at = cyc; end
  initial forever begin @(posedge b_init_done); b_init_at = cyc; end
  initial forever begin @(posedge b_update_done); b_done_at = cyc; end

  function automatic logic [23:0] model_frame(int rg, int addr, int d16);
    return 24'((rg << 19) | (addr << 16) | (d16 & 32'hFFFF));
  endfunction

  function automatic fq_t model_init(int nch, int rc);
    fq_t q;
    q.push_back(model_frame(2, 0, 32'h10 | ((1 << nch) - 1)));
    for (int c = 0; c < nch; c++) q.push_back(model_frame(1, c, rc));
    return q;
  endfunction

  function automatic fq_t model_update(int nch, int w, logic [3:0] en, logic [63:0] d);
    fq_t q;
    for (int c = 0; c < nch; c++)
      if (en[c]) q.push_back(model_frame(0, c, int'((d >> (c*w)) & ((64'd1 << w) - 1)) << (16 - w)));
    return q;
  endfunction

  function automatic logic sig(int which);
    case (which)
      0:       return a_update_done;
      1:       return a_init_done;
      default: return b_update_done;
    endcase
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input fq_t got, input fq_t exp);
    chk({tag, "_count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_%0d", tag, i), 64'(got[i]), 64'(exp[i]));
  endtask

  task automatic wait_for(input string tag, input int which, input int budget);
    for (int i = 0; i < budget && !sig(which); i++) tick();
    chk(tag, 64'(sig(which)), 64'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sync"}, a_sync_n, 1'b1);
    chk({tag, "_sclk"}, a_sclk, 1'b1);
    chk({tag, "_sdin"}, a_sdin, 1'b0);
    chk({tag, "_ldac_a"}, a_ldac_n, 1'b0);
    chk({tag, "_ldac_b"}, b_ldac_n, 1'b1);
    chk({tag, "_clr"}, {a_clr_n, b_clr_n}, 2'b11);
    chk({tag, "_busy"}, {a_busy, b_busy}, 2'b00);
    chk({tag, "_init"}, {a_init_done, b_init_done}, 2'b00);
    chk({tag, "_upd"}, {a_update_done, b_update_done}, 2'b00);
    chk({tag, "_bsync"}, {b_sync_n, b_sclk}, 2'b11);
  endtask

  task automatic a_update(input string tag, input logic [3:0] en, input logic [63:0] d);
    fq_t exp;
    int k, n;
    exp = model_update(A_N, A_W, en, d);
    n = exp.size();
    a_frames.delete(); a_falls.delete();
    a_en = en; a_data = d; a_trig = 1'b1; k = cyc;
    tick();
    a_trig = 1'b0;
    a_en = ~en; a_data = {$urandom, $urandom};
    chk({tag, "_busy_rise"}, a_busy, 1'b1);
    wait_for({tag, "_done"}, 0, 2000);
    chk({tag, "_dur"}, 64'(cyc - k), 64'(n*(48*A_D + A_G) + 1));
    if (n > 0) chk({tag, "_lat"}, 64'(a_falls.size() > 0 ? a_falls[0] - k : -1), 64'd1);
    else       chk({tag, "_nosync"}, 64'(a_falls.size()), 64'd0);
    chk_q(tag, a_frames, exp);
    tick();
    chk({tag, "_busy_fall"}, {a_busy, a_update_done}, 2'b00);
  endtask

  initial begin
    fq_t exp, q2;
    logic [63:0] d1, d2;
    int k, e;
    reset_n = 1'b0; a_trig = 1'b0; b_trig = 1'b0;
    a_en = '0; b_en = 2'b10; a_data = '0; b_data = {12'hFFF, 12'h123};
    tick(3);
    chk_idle("rst");

    // release; B gets a trigger during init that must run once init completes
    reset_n = 1'b1;
    tick(20);
    b_trig = 1'b1; tick(); b_trig = 1'b0;
    wait_for("a_init", 1, 1500);
    chk("a_init_time", 64'(a_init_at - (a_falls.size() > 0 ? a_falls[0] : 0)), 64'(5*(48*A_D + A_G)));
    chk_q("a_initfr", a_frames, model_init(A_N, 0));
    tick(10);
    exp = model_init(B_N, int'(B_RC));
    q2 = model_update(B_N, B_W, 4'b0010, 64'hFFF123);
    foreach (q2[i]) exp.push_back(q2[i]);
    chk_q("b_frames", b_frames, exp);
    chk("b_init_time", 64'(b_init_at - (b_falls.size() > 0 ? b_falls[0] : 0)), 64'(3*(48*B_D + B_G)));
    chk("b_pend_lat", 64'(b_falls.size() > 3 ? b_falls[3] - b_init_at : -1), 64'd1);
    chk("b_ldac_cnt", 64'(b_ldac_cnt), 64'd1);
    chk("b_ldac_start", 64'(b_ldac_fall - b_rise_at), 64'(B_G));
    chk("b_ldac_width", 64'(b_ldac_rise - b_ldac_fall), 64'(2*B_D));
    chk("b_done_time", 64'(b_done_at - b_init_at), 64'(48*B_D + B_G + 2*B_D + 1));
    chk("b_idle", {b_busy, b_ldac_n}, 2'b01);

    a_update("dir", 4'b0101, 64'h0000_ABCD_0000_1234);
    a_update("zero", 4'b0000, {$urandom, $urandom});
    for (int r = 0; r < 4; r++)
      a_update($sformatf("rnd%0d", r), 4'($urandom_range(1, 15)), {$urandom, $urandom});

    // triggers during an update merge into one deferred update using the data seen at IDLE
    d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom};
    exp = model_update(A_N, A_W, 4'b0011, d1);
    a_frames.delete(); a_falls.delete();
    a_en = 4'b0011; a_data = d1; a_trig = 1'b1; k = cyc;
    tick();
    a_trig = 1'b0;
    for (int t = 0; t < 3; t++) begin tick(30); a_trig = 1'b1; tick(); a_trig = 1'b0; end
    a_en = 4'b1100; a_data = d2;
    wait_for("p_done1", 0, 2000);
    e = cyc;
    chk("p_dur1", 64'(e - k), 64'(2*(48*A_D + A_G) + 1));
    tick();
    chk("p_gap_busy", a_busy, 1'b0);
    tick();
    chk("p_restart", 64'(a_falls.size() > 2 ? a_falls[2] - e : -1), 64'd2);
    chk("p_busy2", a_busy, 1'b1);
    wait_for("p_done2", 0, 2000);
    chk("p_dur2", 64'(cyc - e), 64'(1 + 2*(48*A_D + A_G) + 1));
    q2 = model_update(A_N, A_W, 4'b1100, d2);
    foreach (q2[i]) exp.push_back(q2[i]);
    chk_q("p_frames", a_frames, exp);
    tick(300);
    chk("p_single", 64'(a_falls.size()), 64'd4);
    chk("p_idle", a_busy, 1'b0);

    // reset in the middle of a frame
    a_en = 4'hF; a_data = {$urandom, $urandom}; a_trig = 1'b1;
    tick();
    a_trig = 1'b0;
    for (int i = 0; i < 500 && a_bits < 10; i++) tick();
    chk("mid_bits", 64'(a_bits), 64'd10);
    #2 reset_n = 1'b0;
    #1 chk_idle("mid_rst");
    chk("mid_partial", 64'(a_partial), 64'd1);
    tick(3);
    a_frames.delete(); a_falls.delete();
    reset_n = 1'b1;
    wait_for("re_init", 1, 1500);
    chk_q("re_initfr", a_frames, model_init(A_N, 0));
    chk("re_init_time", 64'(a_init_at - (a_falls.size() > 0 ? a_falls[0] : 0)), 64'(5*(48*A_D + A_G)));
    tick(5);
    chk("re_idle", {a_busy, a_update_done}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
